// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: absolute value on entry, sign restore on exit.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply (shift-add) / divide (restoring) unit with HI/LO result registers.
// Optional macro MULDIV_EARLY_OUT_EN skips iteration for zero operands / divide by zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, neg_lo_q, neg_hi_q, dz_q, done_q;
    logic [WIDTH-1:0]   opb_q, a_raw_q, rem_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc_q;

    // Operand preparation
    logic             sgn_in, neg_a, neg_b, div_in, a_zero, b_zero, skip_calc;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign sgn_in = op_is_signed(op);
    assign div_in = op_is_div(op);
    assign neg_a  = sgn_in & a[WIDTH-1];
    assign neg_b  = sgn_in & b[WIDTH-1];
    assign a_zero = (a == '0);
    assign b_zero = (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
    assign skip_calc = div_in ? b_zero : (a_zero | b_zero);
`else
    assign skip_calc = 1'b0;
`endif

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.val(a), .neg(neg_a), .res(abs_a));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.val(b), .neg(neg_b), .res(abs_b));

    // One multiply step: conditional add into the upper half, then shift right
    logic [WIDTH:0]     mul_add, mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_add  = acc_q[0] ? {1'b0, opb_q} : '0;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_add;
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-divide step; the shifted remainder carries the guard bit
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;

    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[WIDTH];

    // Result fixup
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_signfix #(.W(2 * WIDTH)) u_fix_prod (.val(acc_q), .neg(neg_lo_q), .res(prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_quo (.val(acc_q[WIDTH-1:0]), .neg(neg_lo_q),
                                           .res(quo_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (.val(rem_q), .neg(neg_hi_q), .res(rem_fix));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            opb_q    <= '0;
            a_raw_q  <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        is_div_q <= div_in;
                        neg_lo_q <= neg_a ^ neg_b;
                        neg_hi_q <= neg_a;
                        dz_q     <= div_in & b_zero;
                        a_raw_q  <= a;
                        opb_q    <= div_in ? abs_b : abs_a;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        // Zero product preloaded so an early-out FIX sees the final value
                        if (div_in)
                            acc_q <= {{WIDTH{1'b0}}, abs_a};
                        else if (a_zero || b_zero)
                            acc_q <= '0;
                        else
                            acc_q <= {{WIDTH{1'b0}}, abs_b};
                        state_q <= skip_calc ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (is_div_q) begin
                            rem_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                        end else begin
                            acc_q <= mul_next;
                        end
                        if (cnt_q == LAST_ITER) state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!abort) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (dz_q) begin
                            hi_q <= a_raw_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Presents an operation for one edge, then scrambles the inputs.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
    endtask

    task automatic wait_done(output int lat, output int bcyc);
        lat = 0; bcyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat >= 200) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d edges, required done", lat);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_lo: got %h want 0", lo); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int lat, bcyc;
        start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bcyc);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
        checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (bcyc != 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", bcyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        // Issued in the done cycle
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(lat, bcyc);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_divu_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_divu_hi: got %h want 00000002", hi); end
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    endtask

    task automatic test_signed_div();
        int lat, bcyc;
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcyc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bcyc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi: got %h want 00000001", hi); end
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        start_op(2'b11, 32'h1234_5678, 32'h0);
        wait_done(lat, bcyc);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL divu0_hi: got %h want 12345678", hi); end
        checks++; if (lat != ZERO_LAT) begin errors++; $display("FAIL divu0_latency: got %0d want %0d", lat, ZERO_LAT); end
        start_op(2'b10, 32'h8000_0005, 32'h0);
        wait_done(lat, bcyc);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h8000_0005) begin errors++; $display("FAIL div0_hi: got %h want 80000005", hi); end
        start_op(2'b00, 32'h0, 32'hFFFF_FFFB);
        wait_done(lat, bcyc);
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL mult0_result: got %h want 0", {hi, lo}); end
        checks++; if (lat != ZERO_LAT) begin errors++; $display("FAIL mult0_latency: got %0d want %0d", lat, ZERO_LAT); end
    endtask

    task automatic test_start_ignored();
        int lat, bcyc;
        start_op(2'b01, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcyc);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %h want 0000002a", lo); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy %b want 0", busy); end
    endtask

    task automatic test_abort();
        int dcount = 0;
        start_op(2'b01, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        checks++; if (dcount != 0) begin errors++; $display("FAIL abort_late_done: got %0d pulses want 0", dcount); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL abort_lo: got %h want 0000002a", lo); end
    endtask

    task automatic test_reset_mid();
        int dcount = 0;
        start_op(2'b10, 32'd100, 32'd3);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo: got %h want 0", {hi, lo}); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        checks++; if (dcount != 0) begin errors++; $display("FAIL rstmid_late_done: got %0d pulses want 0", dcount); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_signed_div();
        test_div_zero();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
